mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM pipeline stage, sitting directly downstream of the EX/MEM pipeline register.
- Consumes the registered EX results (destination, write enable, ALU result/address, store data, memory op) and performs loads/stores over a req/ack data bus.
- Formats load data and produces registered writeback results for the WB stage (acts as MEM stage plus MEM/WB register).
- Stalls the upstream pipeline while a bus access is outstanding, and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles dbus_req may stay high without dbus_ack before abort (>=2)
- CNT_W, 5, width of timeout counter; must hold TIMEOUT_CYCLES-1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- in_memop  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
- in_wd  in  5  destination register index
- in_wreg  in  1  register write enable
- in_wdata  in  32  ALU result; also the byte address for memory ops
- in_store_data  in  32  rt value for stores
- dbus_req  out  1  bus request, registered
- dbus_we  out  1  1 = store
- dbus_addr  out  32  word-aligned address ({in_wdata[31:2],2'b00})
- dbus_sel  out  4  byte-lane enables, little-endian (lane0 = bits 7:0 = addr[1:0]==0)
- dbus_wdata  out  32  store data replicated to the selected lanes
- dbus_rdata  in  32  read data, valid when dbus_ack=1
- dbus_ack  in  1  completion, sampled in BUSY
- out_wd  out  5  to WB
- out_wreg  out  1  to WB
- out_wdata  out  32  to WB
- out_exc  out  2  0 none, 1 load misaligned, 2 store misaligned, 3 bus timeout; one-cycle pulse
- stall_req  out  1  combinational; 1 = upstream holds EX/MEM contents

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, counter=0, every registered output 0 (dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata, out_*). Reset mid-access drops dbus_req at once, with no completion or exception.
- FSM states: IDLE, BUSY.
- IDLE with NONE op: at the edge, out_wd/out_wreg/out_wdata <= inputs, out_exc<=0. stall_req=0. One-cycle latency.
- IDLE with a misaligned mem op (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0):
  - No bus access; stall_req=0.
  - Next edge: out_wreg<=0, out_wd<=in_wd, out_wdata<=in_wdata (bad address), out_exc<=1 for loads, 2 for stores.
- IDLE with an aligned mem op:
  - stall_req=1.
  - Next edge: register dbus_addr/sel/we/wdata, dbus_req<=1, counter<=0, state<=BUSY, out_wreg<=0 (bubble), out_exc<=0.
- BUSY:
  - dbus_* held stable until ack; stall_req = !dbus_ack && !(counter==TIMEOUT_CYCLES-1).
  - Upstream inputs are stable throughout (held by stall).
  - dbus_ack=1: at the edge, dbus_req<=0, state<=IDLE, out_wd<=in_wd, out_exc<=0.
    - Loads: out_wreg<=in_wreg, out_wdata<=formatted data.
    - Stores: out_wreg<=0.
  - No ack, counter==TIMEOUT_CYCLES-1: abort; dbus_req<=0, state<=IDLE, out_wreg<=0, out_exc<=3.
  - Otherwise: counter<=counter+1.
- Ack and timeout in the same cycle: ack wins.
- Minimum mem-op occupancy is 2 cycles (ack in the first BUSY cycle). Back-to-back mem ops return to IDLE for at least one cycle between accesses.
- Byte select and store data:
  - SB: sel = 1<<addr[1:0], data replicated x4.
  - SH: sel = addr[1] ? 4'b1100 : 4'b0011, data replicated x2.
  - SW: sel = 4'b1111.
- Load formatting: extract the addressed byte/halfword from dbus_rdata; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- dbus_ack outside BUSY is ignored.

Decomposition:
- Shared package/defines: memop encodings (MEMOP_NONE..MEMOP_SW), exc codes (EXC_NONE, EXC_ADEL, EXC_ADES, EXC_BUSTO), state encodings.
- One natural combinational sub-module: mem_lane_fmt. Inputs: memop, addr[1:0], store data, rdata. Outputs: sel, replicated wdata, extended load data, misaligned flag.

Test Plan:
- NONE op, wd=3, wreg=1, wdata=0x1234 -> next cycle out=3/1/0x1234, stall_req=0 throughout.
- LB addr=0x103, rdata=0x80FF_FF_FF, ack 3 cycles after req -> dbus_addr=0x100, sel=1000, stall_req high until the ack cycle, out_wdata=0xFFFFFF80, out_wreg=1.
- SH addr=0x202, store=0xABCD1234, immediate ack -> sel=1100, dbus_wdata=0x12341234, dbus_we=1, out_wreg=0, stall 1 cycle.
- LW addr=0x102 -> no dbus_req, out_exc=1 for one cycle, out_wreg=0, stall_req=0.
- SW with dbus_ack never asserted, TIMEOUT_CYCLES=16 -> dbus_req high exactly 16 cycles, then out_exc=3, state IDLE.
- LHU in BUSY, rst pulled low mid-wait -> dbus_req=0 and all outputs 0 immediately; after release, a NONE op passes normally.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: memory op codes, exception codes and FSM states.
package mem_access_stage_pkg;

    localparam logic [3:0] MEMOP_NONE = 4'd0;
    localparam logic [3:0] MEMOP_LB   = 4'd1;
    localparam logic [3:0] MEMOP_LBU  = 4'd2;
    localparam logic [3:0] MEMOP_LH   = 4'd3;
    localparam logic [3:0] MEMOP_LHU  = 4'd4;
    localparam logic [3:0] MEMOP_LW   = 4'd5;
    localparam logic [3:0] MEMOP_SB   = 4'd6;
    localparam logic [3:0] MEMOP_SH   = 4'd7;
    localparam logic [3:0] MEMOP_SW   = 4'd8;

    localparam logic [1:0] EXC_NONE  = 2'd0;
    localparam logic [1:0] EXC_ADEL  = 2'd1;
    localparam logic [1:0] EXC_ADES  = 2'd2;
    localparam logic [1:0] EXC_BUSTO = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic is_load_op(input logic [3:0] op);
        return (op >= MEMOP_LB) && (op <= MEMOP_LW);
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        return (op >= MEMOP_SB) && (op <= MEMOP_SW);
    endfunction

endpackage

// File: rtl/mem_access_stage_lane_fmt.sv
// Byte-lane logic: lane selects, store-data replication, load extraction/extension
// and alignment checking for one memory op.
module mem_lane_fmt
    import mem_access_stage_pkg::*;
(
    input  logic [3:0]  memop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        sel        = 4'b0000;
        wdata      = store_data;
        load_data  = rdata;
        misaligned = 1'b0;
        case (memop)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: begin
                sel   = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: begin
                sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                misaligned = addr_lo[0];
            end
            MEMOP_LW, MEMOP_SW: begin
                sel        = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            default: ;
        endcase
        case (memop)
            MEMOP_LB:  load_data = {{24{byte_v[7]}}, byte_v};
            MEMOP_LBU: load_data = {24'h0, byte_v};
            MEMOP_LH:  load_data = {{16{half_v[15]}}, half_v};
            MEMOP_LHU: load_data = {16'h0, half_v};
            default:   load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage plus MEM/WB register: issues loads/stores over a req/ack bus,
// stalls upstream while an access is outstanding and reports address/timeout faults.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  in_memop,
    input  logic [4:0]  in_wd,
    input  logic        in_wreg,
    input  logic [31:0] in_wdata,
    input  logic [31:0] in_store_data,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic [4:0]  out_wd,
    output logic        out_wreg,
    output logic [31:0] out_wdata,
    output logic [1:0]  out_exc,
    output logic        stall_req
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, next_state;
    logic [CNT_W-1:0]  counter;
    logic [3:0]        fmt_sel;
    logic [31:0]       fmt_wdata;
    logic [31:0]       fmt_load;
    logic              fmt_misaligned;
    logic              is_load, is_store, is_mem, timed_out;

    assign is_load   = is_load_op(in_memop);
    assign is_store  = is_store_op(in_memop);
    assign is_mem    = is_load | is_store;
    assign timed_out = (counter == CNT_LAST);

    mem_lane_fmt u_lane_fmt (
        .memop      (in_memop),
        .addr_lo    (in_wdata[1:0]),
        .store_data (in_store_data),
        .rdata      (dbus_rdata),
        .sel        (fmt_sel),
        .wdata      (fmt_wdata),
        .load_data  (fmt_load),
        .misaligned (fmt_misaligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (is_mem && !fmt_misaligned) next_state = ST_BUSY;
            ST_BUSY: if (dbus_ack || timed_out)     next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_req = 1'b0;
        case (state)
            ST_IDLE: stall_req = is_mem && !fmt_misaligned;
            ST_BUSY: stall_req = !dbus_ack && !timed_out;
            default: stall_req = 1'b0;
        endcase
    end

    // Bus and writeback registers; upstream inputs stay frozen by the stall while BUSY,
    // so the lane formatter can be reused on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter    <= '0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_sel   <= '0;
            dbus_wdata <= '0;
            out_wd     <= '0;
            out_wreg   <= 1'b0;
            out_wdata  <= '0;
            out_exc    <= EXC_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    out_wd    <= in_wd;
                    out_wdata <= in_wdata;
                    out_exc   <= EXC_NONE;
                    if (is_mem && fmt_misaligned) begin
                        out_wreg <= 1'b0;
                        out_exc  <= is_load ? EXC_ADEL : EXC_ADES;
                    end else if (is_mem) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= is_store;
                        dbus_addr  <= {in_wdata[31:2], 2'b00};
                        dbus_sel   <= fmt_sel;
                        dbus_wdata <= fmt_wdata;
                        counter    <= '0;
                        out_wreg   <= 1'b0;
                    end else begin
                        out_wreg <= in_wreg;
                    end
                end
                ST_BUSY: begin
                    if (dbus_ack) begin
                        dbus_req  <= 1'b0;
                        out_wd    <= in_wd;
                        out_exc   <= EXC_NONE;
                        out_wreg  <= is_load ? in_wreg : 1'b0;
                        out_wdata <= is_load ? fmt_load : in_wdata;
                    end else if (timed_out) begin
                        dbus_req <= 1'b0;
                        out_wreg <= 1'b0;
                        out_exc  <= EXC_BUSTO;
                    end else begin
                        counter <= counter + 1'b1;
                        out_exc <= EXC_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_memop;
    logic [4:0]  in_wd;
    logic        in_wreg;
    logic [31:0] in_wdata;
    logic [31:0] in_store_data;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic [4:0]  out_wd;
    logic        out_wreg;
    logic [31:0] out_wdata;
    logic [1:0]  out_exc;
    logic        stall_req;

    int checks   = 0;
    int failures = 0;
    int req_cycles;

    mem_access_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_memop      (in_memop),
        .in_wd         (in_wd),
        .in_wreg       (in_wreg),
        .in_wdata      (in_wdata),
        .in_store_data (in_store_data),
        .dbus_req      (dbus_req),
        .dbus_we       (dbus_we),
        .dbus_addr     (dbus_addr),
        .dbus_sel      (dbus_sel),
        .dbus_wdata    (dbus_wdata),
        .dbus_rdata    (dbus_rdata),
        .dbus_ack      (dbus_ack),
        .out_wd        (out_wd),
        .out_wreg      (out_wreg),
        .out_wdata     (out_wdata),
        .out_exc       (out_exc),
        .stall_req     (stall_req)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                                 input logic [31:0] wdata, input logic [31:0] sdata);
        in_memop      = op;
        in_wd         = wd;
        in_wreg       = wreg;
        in_wdata      = wdata;
        in_store_data = sdata;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        dbus_ack   = 1'b0;
        dbus_rdata = 32'h0;
        applyStimulus(4'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("reset_req", dbus_req, 0);
        checkOutput("reset_addr", dbus_addr, 0);
        checkOutput("reset_out_wdata", out_wdata, 0);
        checkOutput("reset_exc", out_exc, 0);
        #10;
        rst = 1'b1;
        tick();

        // NONE op passes through with one-cycle latency
        applyStimulus(4'd0, 5'd3, 1'b1, 32'h1234, 32'h0);
        checkOutput("none_stall", stall_req, 0);
        tick();
        checkOutput("none_wd", out_wd, 3);
        checkOutput("none_wreg", out_wreg, 1);
        checkOutput("none_wdata", out_wdata, 32'h1234);

        // LB at 0x103, ack on the third BUSY cycle
        applyStimulus(4'd1, 5'd7, 1'b1, 32'h103, 32'h0);
        checkOutput("lb_stall_idle", stall_req, 1);
        tick();
        checkOutput("lb_req", dbus_req, 1);
        checkOutput("lb_addr", dbus_addr, 32'h100);
        checkOutput("lb_sel", dbus_sel, 4'b1000);
        checkOutput("lb_we", dbus_we, 0);
        checkOutput("lb_bubble", out_wreg, 0);
        for (int i = 0; i < 2; i++) begin
            checkOutput("lb_stall_wait", stall_req, 1);
            tick();
            checkOutput("lb_req_held", dbus_req, 1);
        end
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h80FF_FFFF;
        #1;
        checkOutput("lb_stall_ack", stall_req, 0);
        tick();
        dbus_ack = 1'b0;
        checkOutput("lb_req_drop", dbus_req, 0);
        checkOutput("lb_wreg", out_wreg, 1);
        checkOutput("lb_wd", out_wd, 7);
        checkOutput("lb_wdata", out_wdata, 32'hFFFF_FF80);

        // SH at 0x202 with ack already high in IDLE (ignored there), completes immediately
        applyStimulus(4'd7, 5'd4, 1'b1, 32'h202, 32'hABCD_1234);
        dbus_ack = 1'b1;
        #1;
        checkOutput("sh_stall_idle", stall_req, 1);
        tick();
        checkOutput("sh_req", dbus_req, 1);
        checkOutput("sh_sel", dbus_sel, 4'b1100);
        checkOutput("sh_wdata", dbus_wdata, 32'h1234_1234);
        checkOutput("sh_we", dbus_we, 1);
        checkOutput("sh_addr", dbus_addr, 32'h200);
        checkOutput("sh_stall_busy", stall_req, 0);
        tick();
        dbus_ack = 1'b0;
        checkOutput("sh_done_req", dbus_req, 0);
        checkOutput("sh_wreg", out_wreg, 0);
        checkOutput("sh_exc", out_exc, 0);

        // LW misaligned: no bus, one-cycle load address exception
        applyStimulus(4'd5, 5'd6, 1'b1, 32'h102, 32'h0);
        checkOutput("lw_mis_stall", stall_req, 0);
        tick();
        checkOutput("lw_mis_req", dbus_req, 0);
        checkOutput("lw_mis_exc", out_exc, 1);
        checkOutput("lw_mis_wreg", out_wreg, 0);
        checkOutput("lw_mis_wdata", out_wdata, 32'h102);
        applyStimulus(4'd0, 5'd1, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("lw_mis_pulse", out_exc, 0);

        // SH misaligned: store address exception
        applyStimulus(4'd7, 5'd2, 1'b0, 32'h201, 32'h0);
        tick();
        checkOutput("sh_mis_exc", out_exc, 2);
        checkOutput("sh_mis_req", dbus_req, 0);

        // SB lane 1 replication and LBU zero-extension on lane 1
        applyStimulus(4'd6, 5'd0, 1'b0, 32'h301, 32'h0000_005A);
        tick();
        checkOutput("sb_sel", dbus_sel, 4'b0010);
        checkOutput("sb_wdata", dbus_wdata, 32'h5A5A_5A5A);
        dbus_ack = 1'b1;
        tick();
        dbus_ack = 1'b0;
        applyStimulus(4'd2, 5'd8, 1'b1, 32'h301, 32'h0);
        tick();
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h0000_A500;
        tick();
        dbus_ack = 1'b0;
        checkOutput("lbu_wdata", out_wdata, 32'h0000_00A5);

        // LH upper half sign-extension
        applyStimulus(4'd3, 5'd9, 1'b1, 32'h002, 32'h0);
        tick();
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h8001_7777;
        tick();
        dbus_ack = 1'b0;
        checkOutput("lh_wdata", out_wdata, 32'hFFFF_8001);

        // SW with no ack: request held exactly TIMEOUT_CYCLES cycles, then bus timeout
        applyStimulus(4'd8, 5'd5, 1'b0, 32'h300, 32'hDEAD_BEEF);
        tick();
        req_cycles = 0;
        for (int i = 0; i < 40 && dbus_req; i++) begin
            req_cycles++;
            tick();
        end
        checkOutput("sw_to_cycles", req_cycles, 16);
        checkOutput("sw_to_exc", out_exc, 3);
        checkOutput("sw_to_wreg", out_wreg, 0);
        applyStimulus(4'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        checkOutput("sw_to_idle_stall", stall_req, 0);
        tick();

        // LHU with reset asserted mid-wait
        applyStimulus(4'd4, 5'd10, 1'b1, 32'h402, 32'h0);
        tick();
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_req", dbus_req, 0);
        checkOutput("rst_mid_sel", dbus_sel, 0);
        checkOutput("rst_mid_wd", out_wd, 0);
        checkOutput("rst_mid_exc", out_exc, 0);
        applyStimulus(4'd0, 5'd9, 1'b1, 32'h55, 32'h0);
        rst = 1'b1;
        tick();
        checkOutput("post_rst_wd", out_wd, 9);
        checkOutput("post_rst_wreg", out_wreg, 1);
        checkOutput("post_rst_wdata", out_wdata, 32'h55);
        checkOutput("post_rst_req", dbus_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
